// File: rtl/decimal_entry.sv
`timescale 1ns/1ps
`default_nettype none
// +==========================================================================+
// | decimal_entry: debounced key entry of a decimal number into a binary reg |
// | Rev 1.0                                                                  |
// +==========================================================================+
module decimal_entry #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        iClk_50,
  input  logic        nRst,
  input  logic [3:0]  iDigit,
  input  logic        nKeyEnter,
  input  logic        nKeyDone,
  input  logic        nKeyClear,
  output logic [31:0] oEntry,
  output logic [2:0]  oCount,
  output logic [31:0] oNum,
  output logic        oValid,
  output logic        oErr
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      LAST_AT = 3'(DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  // Key bit order: [0]=enter, [1]=done, [2]=clear
  logic [2:0] key_raw;
  logic [2:0] key_s1_q, key_s2_q;
  logic [3:0] digit_s1_q, digit_s2_q;
  logic [2:0] key_ev;

  assign key_raw = {nKeyClear, nKeyDone, nKeyEnter};

  always_ff @(posedge iClk_50 or negedge nRst) begin
    if (!nRst) begin
      key_s1_q   <= 3'b111;
      key_s2_q   <= 3'b111;
      digit_s1_q <= 4'd0;
      digit_s2_q <= 4'd0;
    end else begin
      key_s1_q   <= key_raw;
      key_s2_q   <= key_s1_q;
      digit_s1_q <= iDigit;
      digit_s2_q <= digit_s1_q;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_debounce
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             level_d, level_q, level_prev_q;

    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (key_s2_q[k] != level_q) begin
        if (cnt_q == DB_MAX) level_d = key_s2_q[k];
        else                 cnt_d   = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge iClk_50 or negedge nRst) begin
      if (!nRst) begin
        cnt_q        <= '0;
        level_q      <= 1'b1;
        level_prev_q <= 1'b1;
      end else begin
        cnt_q        <= cnt_d;
        level_q      <= level_d;
        level_prev_q <= level_q;
      end
    end

    // Press only: a debounced high-to-low step, one cycle wide.
    assign key_ev[k] = level_prev_q & ~level_q;
  end

  logic [1:0]  state_d, state_q;
  logic [31:0] entry_d, entry_q;
  logic [2:0]  count_d, count_q;
  logic [31:0] num_d, num_q;
  logic        valid_d, valid_q;
  logic        err_d, err_q;

  logic        ev_enter, ev_done, ev_clear;
  logic        digit_ok, accept;
  logic [31:0] entry_x10;

  assign ev_enter  = key_ev[0];
  assign ev_done   = key_ev[1];
  assign ev_clear  = key_ev[2];
  assign digit_ok  = (digit_s2_q <= 4'd9);
  assign accept    = ev_enter & ~ev_done & ~ev_clear & digit_ok & (state_q != S_FULL);
  assign entry_x10 = {entry_q[28:0], 3'b000} + {entry_q[30:0], 1'b0};

  always_ff @(posedge iClk_50 or negedge nRst) begin
    if (!nRst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ev_clear || ev_done) state_d = S_IDLE;
    else if (accept)         state_d = (count_q == LAST_AT) ? S_FULL : S_ENTRY;
  end

  // Priority clear > done > enter; the losers are simply dropped.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    num_d   = num_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (ev_clear) begin
      entry_d = '0;
      count_d = '0;
    end else if (ev_done) begin
      num_d   = entry_q;
      valid_d = 1'b1;
      entry_d = '0;
      count_d = '0;
    end else if (ev_enter) begin
      if (accept) begin
        entry_d = entry_x10 + {28'd0, digit_s2_q};
        count_d = count_q + 3'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk_50 or negedge nRst) begin
    if (!nRst) begin
      entry_q <= '0;
      count_q <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign oEntry = entry_q;
  assign oCount = count_q;
  assign oNum   = num_q;
  assign oValid = valid_q;
  assign oErr   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decimal_entry.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for decimal_entry: keyed operations against a table of expected results.
module tb_decimal_entry;

  localparam logic [2:0] KE = 3'b001;
  localparam logic [2:0] KD = 3'b010;
  localparam logic [2:0] KC = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  iDigit;
  logic        nKeyEnter, nKeyDone, nKeyClear;
  logic [31:0] oEntry, oNum;
  logic [2:0]  oCount;
  logic        oValid, oErr;

  always #5 clk = ~clk;

  decimal_entry #(.DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
    .iClk_50   (clk),
    .nRst      (rst_n),
    .iDigit    (iDigit),
    .nKeyEnter (nKeyEnter),
    .nKeyDone  (nKeyDone),
    .nKeyClear (nKeyClear),
    .oEntry    (oEntry),
    .oCount    (oCount),
    .oNum      (oNum),
    .oValid    (oValid),
    .oErr      (oErr)
  );

  typedef struct {
    logic [2:0]  keys;
    logic [3:0]  digit;
    logic [31:0] entry;
    logic [2:0]  count;
    logic [31:0] num;
    int          valid_n;
    int          err_n;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   valid_seen = 0;
  int   err_seen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (oValid) valid_seen <= valid_seen + 1;
      if (oErr)   err_seen   <= err_seen + 1;
    end
  end

  function automatic vec_t mk(logic [2:0] k, logic [3:0] d, logic [31:0] e,
                              logic [2:0] c, logic [31:0] n, int v, int r);
    vec_t t;
    t.keys = k; t.digit = d; t.entry = e; t.count = c; t.num = n;
    t.valid_n = v; t.err_n = r;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic score(int v0, int e0, string tag);
    vec_t x;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    x = sb.pop_front();
    check({tag, " entry"}, oEntry, x.entry);
    check({tag, " count"}, 32'(oCount), 32'(x.count));
    check({tag, " num"},   oNum, x.num);
    check({tag, " valid"}, 32'(valid_seen - v0), 32'(x.valid_n));
    check({tag, " err"},   32'(err_seen - e0), 32'(x.err_n));
  endtask

  task automatic run_op(vec_t v, string tag);
    int v0, e0;
    sb.push_back(v);
    v0 = valid_seen;
    e0 = err_seen;
    @(negedge clk);
    iDigit = v.digit;
    {nKeyClear, nKeyDone, nKeyEnter} = ~v.keys;
    repeat (10) @(negedge clk);
    {nKeyClear, nKeyDone, nKeyEnter} = 3'b111;
    repeat (10) @(negedge clk);
    score(v0, e0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;
    vecs.push_back(mk(KE,      4'd1,  32'd1,    3'd1, 32'd0,    0, 0));
    vecs.push_back(mk(KE,      4'd2,  32'd12,   3'd2, 32'd0,    0, 0));
    vecs.push_back(mk(KE,      4'd3,  32'd123,  3'd3, 32'd0,    0, 0));
    vecs.push_back(mk(KE,      4'd4,  32'd1234, 3'd4, 32'd0,    0, 0));
    vecs.push_back(mk(KD,      4'd0,  32'd0,    3'd0, 32'd1234, 1, 0));
    vecs.push_back(mk(KE,      4'd9,  32'd9,    3'd1, 32'd1234, 0, 0));
    vecs.push_back(mk(KE,      4'd9,  32'd99,   3'd2, 32'd1234, 0, 0));
    vecs.push_back(mk(KE,      4'd9,  32'd999,  3'd3, 32'd1234, 0, 0));
    vecs.push_back(mk(KE,      4'd9,  32'd9999, 3'd4, 32'd1234, 0, 0));
    vecs.push_back(mk(KE,      4'd7,  32'd9999, 3'd4, 32'd1234, 0, 1));
    vecs.push_back(mk(KC,      4'd0,  32'd0,    3'd0, 32'd1234, 0, 0));
    vecs.push_back(mk(KE,      4'd12, 32'd0,    3'd0, 32'd1234, 0, 1));
    vecs.push_back(mk(KE,      4'd5,  32'd5,    3'd1, 32'd1234, 0, 0));
    vecs.push_back(mk(KE,      4'd6,  32'd56,   3'd2, 32'd1234, 0, 0));
    vecs.push_back(mk(KD | KC, 4'd0,  32'd0,    3'd0, 32'd1234, 0, 0));
    vecs.push_back(mk(KD,      4'd0,  32'd0,    3'd0, 32'd0,    1, 0));
    vecs.push_back(mk(KE,      4'd8,  32'd8,    3'd1, 32'd0,    0, 0));
    vecs.push_back(mk(KE | KD, 4'd3,  32'd0,    3'd0, 32'd8,    1, 0));
    vecs.push_back(mk(KE,      4'd15, 32'd0,    3'd0, 32'd8,    0, 1));
    vecs.push_back(mk(KE,      4'd0,  32'd0,    3'd1, 32'd8,    0, 0));
    vecs.push_back(mk(KE | KC, 4'd4,  32'd0,    3'd0, 32'd8,    0, 0));

    rst_n = 1'b0; iDigit = 4'd0;
    nKeyEnter = 1'b1; nKeyDone = 1'b1; nKeyClear = 1'b1;
    repeat (3) @(negedge clk);
    check("reset entry", oEntry, 32'd0);
    check("reset count", 32'(oCount), 32'd0);
    check("reset num", oNum, 32'd0);
    check("reset valid", 32'(oValid), 32'd0);
    check("reset err", 32'(oErr), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Bounce: 3-cycle pulses must never pass, then one clean hold.
    sb.push_back(mk(KE, 4'd3, 32'd3, 3'd1, 32'd8, 0, 0));
    v0 = valid_seen; e0 = err_seen;
    @(negedge clk);
    iDigit = 4'd3;
    for (int p = 0; p < 5; p++) begin
      nKeyEnter = 1'b0; repeat (3) @(negedge clk);
      nKeyEnter = 1'b1; repeat (3) @(negedge clk);
    end
    check("bounce no entry", oEntry, 32'd0);
    nKeyEnter = 1'b0; repeat (10) @(negedge clk);
    nKeyEnter = 1'b1; repeat (10) @(negedge clk);
    score(v0, e0, "bounce");

    run_op(mk(KC, 4'd0, 32'd0,  3'd0, 32'd8, 0, 0), "pre-rst clear");
    run_op(mk(KE, 4'd4, 32'd4,  3'd1, 32'd8, 0, 0), "pre-rst 4");
    run_op(mk(KE, 4'd2, 32'd42, 3'd2, 32'd8, 0, 0), "pre-rst 2");

    // Reset while a key is mid-debounce; the held key must still register once afterwards.
    sb.push_back(mk(KE, 4'd7, 32'd7, 3'd1, 32'd0, 0, 0));
    @(negedge clk);
    iDigit = 4'd7;
    nKeyEnter = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst entry", oEntry, 32'd0);
    check("midrst count", 32'(oCount), 32'd0);
    check("midrst num", oNum, 32'd0);
    check("midrst valid", 32'(oValid), 32'd0);
    check("midrst err", 32'(oErr), 32'd0);
    v0 = valid_seen; e0 = err_seen;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    nKeyEnter = 1'b1;
    repeat (10) @(negedge clk);
    score(v0, e0, "post-rst");

    // Latency: pin low at cycle 0, outputs move on the 7th rising edge with DEBOUNCE_CYCLES=4.
    iDigit = 4'd5;
    nKeyEnter = 1'b0;
    repeat (6) @(negedge clk);
    check("latency early", oEntry, 32'd7);
    @(negedge clk);
    check("latency entry", oEntry, 32'd75);
    check("latency count", 32'(oCount), 32'd2);
    repeat (5) @(negedge clk);
    nKeyEnter = 1'b1;
    repeat (10) @(negedge clk);
    check("latency hold once", oEntry, 32'd75);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
